// File: rtl/input_unit_xy.sv
// input_unit_xy: router input port with flit FIFO, XY route computation and wormhole route lock
//
// Holds incoming flits in a DEPTH-entry FIFO. A head or single flit at the FIFO
// head in IDLE is routed in one cycle, and the route stays locked until the
// tail or single flit transfers. A body or tail flit seen in IDLE has no route:
// it is dropped and sets the sticky err_o.
//
// Optional feature: define IU_PKT_CNT_EN to add pkt_cnt_o, a 16-bit wrapping
// count of transferred tail/single flits.
//
// Ports:
//   clk        clock, all state on rising edge
//   rstn       asynchronous active-low reset
//   flit_i     upstream flit; [FW-1:FW-2] type (00 body, 01 head, 10 tail, 11 single)
//   valid_i    upstream flit valid
//   ready_o    FIFO not full
//   flit_o     FIFO head flit, qualified by valid_o
//   sel_o      one-hot route: 0 local, 1 north, 2 east, 3 south, 4 west
//   valid_o    flit_o valid towards the selected output
//   ready_i    per-output ready
//   err_o      sticky: body/tail flit arrived with no route locked
//   pkt_cnt_o  (IU_PKT_CNT_EN only) delivered packet count
module input_unit_xy #(
   parameter int FLIT_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int X_W        = 3,
   parameter int Y_W        = 3,
   parameter int CUR_X      = 0,
   parameter int CUR_Y      = 0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [FLIT_WIDTH-1:0] flit_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [FLIT_WIDTH-1:0] flit_o,
   output logic [4:0]            sel_o,
   output logic                  valid_o,
   input  logic [4:0]            ready_i,
   output logic                  err_o
`ifdef IU_PKT_CNT_EN
   ,
   output logic [15:0]           pkt_cnt_o
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [X_W-1:0] CX = X_W'(CUR_X);
   localparam logic [Y_W-1:0] CY = Y_W'(CUR_Y);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wr_ptr, r_rd_ptr;
   state_t                r_state;
   logic [4:0]            r_sel;
   logic                  r_err;

   logic                  w_full, w_empty, w_wr, w_rd, w_xfer, w_drop, w_route_now;
   logic [1:0]            w_type;
   logic [X_W-1:0]        w_dx;
   logic [Y_W-1:0]        w_dy;
   logic [4:0]            w_route;

   // extra pointer bit distinguishes full from empty when the indices match
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty = r_wr_ptr == r_rd_ptr;
   assign ready_o = !w_full;
   assign w_wr    = valid_i && !w_full;

   assign flit_o  = r_mem[r_rd_ptr[AW-1:0]];
   assign w_type  = flit_o[FLIT_WIDTH-1 -: 2];
   assign w_dx    = flit_o[FLIT_WIDTH-3 -: X_W];
   assign w_dy    = flit_o[FLIT_WIDTH-3-X_W -: Y_W];

   assign sel_o   = r_sel;
   assign err_o   = r_err;
   assign valid_o = (r_state == ACTIVE) && !w_empty;
   assign w_xfer  = valid_o && |(ready_i & r_sel);

   // type[0] set = head or single; type[1] set = tail or single
   assign w_route_now = (r_state == IDLE) && !w_empty && w_type[0];
   assign w_drop      = (r_state == IDLE) && !w_empty && !w_type[0];
   assign w_rd        = w_xfer || w_drop;

   // X resolved before Y
   always_comb
      w_route = (w_dx > CX) ? 5'b00100 :
                (w_dx < CX) ? 5'b10000 :
                (w_dy > CY) ? 5'b00010 :
                (w_dy < CY) ? 5'b01000 : 5'b00001;

   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= flit_i;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_sel    <= '0;
         r_err    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_drop) r_err <= 1'b1;
         if (w_route_now) begin
            r_state <= ACTIVE;
            r_sel   <= w_route;
         end else if (w_xfer && w_type[1]) begin
            r_state <= IDLE;
            r_sel   <= '0;
         end
      end
   end

`ifdef IU_PKT_CNT_EN
   logic [15:0] r_pkt_cnt;
   assign pkt_cnt_o = r_pkt_cnt;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) r_pkt_cnt <= '0;
      else if (w_xfer && w_type[1]) r_pkt_cnt <= r_pkt_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_input_unit_xy.sv
// tb_input_unit_xy: directed self-checking bench for input_unit_xy (CUR=(1,1))
module tb_input_unit_xy;
   localparam logic [1:0] B = 2'b00, H = 2'b01, T = 2'b10, S = 2'b11;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] flit_i = '0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] flit_o;
   logic [4:0]  sel_o;
   logic        valid_o;
   logic [4:0]  ready_i = '0;
   logic        err_o;
`ifdef IU_PKT_CNT_EN
   logic [15:0] pkt_cnt_o;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_unit_xy #(.FLIT_WIDTH(32), .DEPTH(4), .X_W(3), .Y_W(3), .CUR_X(1), .CUR_Y(1)) dut (
      .clk(clk), .rstn(rstn), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_o),
      .flit_o(flit_o), .sel_o(sel_o), .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o)
`ifdef IU_PKT_CNT_EN
      , .pkt_cnt_o(pkt_cnt_o)
`endif
   );

   function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] x, input logic [2:0] y, input logic [23:0] p);
      return {t, x, y, p};
   endfunction

   task automatic test_reset;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (sel_o !== 5'b0) begin errors++; $display("FAIL reset_sel got %b want 00000", sel_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL post_reset valid=%b ready=%b want 0 1", valid_o, ready_o); end
   endtask

   task automatic test_single;
      logic [31:0] f;
      f = mk(S, 3'd1, 3'd1, 24'h000ABC);
      ready_i = 5'b00001;
      @(negedge clk); flit_i = f; valid_i = 1'b1;
      @(negedge clk); valid_i = 1'b0;
      checks++; if (valid_o !== 1'b0 || sel_o !== 5'b0) begin errors++; $display("FAIL single_route_latency valid=%b sel=%b want 0 00000", valid_o, sel_o); end
      checks++; if (flit_o !== f) begin errors++; $display("FAIL single_flit_head got %h want %h", flit_o, f); end
      @(negedge clk);
      checks++; if (sel_o !== 5'b00001 || valid_o !== 1'b1) begin errors++; $display("FAIL single_local sel=%b valid=%b want 00001 1", sel_o, valid_o); end
      @(negedge clk);
      checks++; if (sel_o !== 5'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL single_idle sel=%b valid=%b want 00000 0", sel_o, valid_o); end
   endtask

   task automatic test_packet;
      logic [31:0] pkt [4];
      int idx;
      pkt[0] = mk(H, 3'd3, 3'd0, 24'h000001);
      pkt[1] = mk(B, 3'd5, 3'd5, 24'h000002);
      pkt[2] = mk(B, 3'd0, 3'd7, 24'h000003);
      pkt[3] = mk(T, 3'd1, 3'd1, 24'h000004);
      ready_i = 5'b11111;
      idx = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (valid_o) begin
            checks++;
            if (idx > 3 || flit_o !== pkt[idx] || sel_o !== 5'b00100) begin errors++; $display("FAIL packet_flit%0d got %h sel %b want east", idx, flit_o, sel_o); end
            idx++;
         end
         valid_i = (c < 4);
         flit_i = pkt[c < 4 ? c : 0];
      end
      valid_i = 1'b0;
      checks++; if (idx !== 4) begin errors++; $display("FAIL packet_count got %0d want 4", idx); end
      checks++; if (sel_o !== 5'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL packet_end sel=%b valid=%b want 00000 0", sel_o, valid_o); end
   endtask

   task automatic test_stall;
      logic [31:0] pkt [4];
      int idx;
      pkt[0] = mk(H, 3'd3, 3'd0, 24'h0000A0);
      pkt[1] = mk(B, 3'd0, 3'd0, 24'h0000A1);
      pkt[2] = mk(B, 3'd0, 3'd0, 24'h0000A2);
      pkt[3] = mk(T, 3'd0, 3'd0, 24'h0000A3);
      ready_i = 5'b11011;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); flit_i = pkt[c]; valid_i = 1'b1;
      end
      @(negedge clk);
      flit_i = mk(S, 3'd1, 3'd1, 24'h00DEAD);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_full ready=%b want 0", ready_o); end
      checks++; if (valid_o !== 1'b1 || sel_o !== 5'b00100 || flit_o !== pkt[0]) begin errors++; $display("FAIL stall_head valid=%b sel=%b flit=%h want 1 00100 %h", valid_o, sel_o, flit_o, pkt[0]); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (valid_o !== 1'b1 || flit_o !== pkt[0] || ready_o !== 1'b0) begin errors++; $display("FAIL stall_hold%0d valid=%b flit=%h ready=%b want 1 %h 0", k, valid_o, flit_o, ready_o, pkt[0]); end
      end
      valid_i = 1'b0;
      ready_i = 5'b11111;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         if (valid_o) begin
            checks++;
            if (idx > 3 || flit_o !== pkt[idx]) begin errors++; $display("FAIL drain_flit%0d got %h want in-order packet", idx, flit_o); end
            idx++;
         end
         @(negedge clk);
      end
      checks++; if (idx !== 4) begin errors++; $display("FAIL drain_count got %0d want 4", idx); end
      checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL drain_end valid=%b ready=%b want 0 1", valid_o, ready_o); end
   endtask

   task automatic test_dirs;
      logic [2:0] xs [7];
      logic [2:0] ys [7];
      logic [4:0] es [7];
      int w;
      xs = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd7, 3'd1};
      ys = '{3'd1, 3'd2, 3'd0, 3'd2, 3'd0, 3'd7, 3'd1};
      es = '{5'b10000, 5'b00010, 5'b01000, 5'b00100, 5'b10000, 5'b00100, 5'b00001};
      ready_i = 5'b11111;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); flit_i = mk(S, xs[i], ys[i], 24'(i)); valid_i = 1'b1;
         @(negedge clk); valid_i = 1'b0;
         w = 0;
         while (!valid_o && w < 5) begin @(negedge clk); w++; end
         checks++;
         if (valid_o !== 1'b1 || sel_o !== es[i]) begin errors++; $display("FAIL route_%0d_%0d valid=%b sel=%b want 1 %b", xs[i], ys[i], valid_o, sel_o, es[i]); end
         @(negedge clk);
         checks++;
         if (sel_o !== 5'b0) begin errors++; $display("FAIL route_clear_%0d sel=%b want 00000", i, sel_o); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] s1, s2;
      s1 = mk(S, 3'd2, 3'd1, 24'h000B01);
      s2 = mk(S, 3'd1, 3'd1, 24'h000B02);
      ready_i = 5'b11111;
      @(negedge clk); flit_i = s1; valid_i = 1'b1;
      @(negedge clk); flit_i = s2;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_latency valid=%b want 0", valid_o); end
      @(negedge clk); valid_i = 1'b0;
      checks++; if (valid_o !== 1'b1 || flit_o !== s1 || sel_o !== 5'b00100) begin errors++; $display("FAIL b2b_first valid=%b flit=%h sel=%b want 1 %h 00100", valid_o, flit_o, sel_o, s1); end
      @(negedge clk);
      checks++; if (valid_o !== 1'b0 || sel_o !== 5'b0) begin errors++; $display("FAIL b2b_bubble valid=%b sel=%b want 0 00000", valid_o, sel_o); end
      @(negedge clk);
      checks++; if (valid_o !== 1'b1 || flit_o !== s2 || sel_o !== 5'b00001) begin errors++; $display("FAIL b2b_second valid=%b flit=%h sel=%b want 1 %h 00001", valid_o, flit_o, sel_o, s2); end
      @(negedge clk);
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end valid=%b want 0", valid_o); end
   endtask

   task automatic test_head_in_active;
      logic [31:0] pkt [3];
      int idx;
      pkt[0] = mk(H, 3'd0, 3'd1, 24'h000C01);
      pkt[1] = mk(H, 3'd3, 3'd3, 24'h000C02);
      pkt[2] = mk(T, 3'd0, 3'd0, 24'h000C03);
      ready_i = 5'b11111;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (valid_o) begin
            checks++;
            if (idx > 2 || flit_o !== pkt[idx] || sel_o !== 5'b10000) begin errors++; $display("FAIL reroute_flit%0d got %h sel %b want west", idx, flit_o, sel_o); end
            idx++;
         end
         valid_i = (c < 3);
         flit_i = pkt[c < 3 ? c : 0];
      end
      valid_i = 1'b0;
      checks++; if (idx !== 3) begin errors++; $display("FAIL reroute_count got %0d want 3", idx); end
   endtask

   task automatic test_err;
      logic [31:0] f;
      int w;
      ready_i = 5'b11111;
      @(negedge clk); flit_i = mk(B, 3'd2, 3'd2, 24'h000E01); valid_i = 1'b1;
      @(negedge clk); valid_i = 1'b0;
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_early got %b want 0", err_o); end
      @(negedge clk);
      checks++; if (err_o !== 1'b1 || valid_o !== 1'b0 || sel_o !== 5'b0) begin errors++; $display("FAIL err_drop err=%b valid=%b sel=%b want 1 0 00000", err_o, valid_o, sel_o); end
      f = mk(S, 3'd1, 3'd1, 24'h000E02);
      @(negedge clk); flit_i = f; valid_i = 1'b1;
      @(negedge clk); valid_i = 1'b0;
      w = 0;
      while (!valid_o && w < 5) begin @(negedge clk); w++; end
      checks++; if (valid_o !== 1'b1 || flit_o !== f) begin errors++; $display("FAIL err_next_pkt valid=%b flit=%h want 1 %h", valid_o, flit_o, f); end
      repeat (2) @(negedge clk);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_o); end
   endtask

   task automatic test_reset_mid;
      ready_i = 5'b00000;
      @(negedge clk); flit_i = mk(H, 3'd3, 3'd0, 24'h000F01); valid_i = 1'b1;
      @(negedge clk); flit_i = mk(B, 3'd0, 3'd0, 24'h000F02);
      @(negedge clk); valid_i = 1'b0;
      checks++; if (valid_o !== 1'b1 || sel_o !== 5'b00100) begin errors++; $display("FAIL rmid_active valid=%b sel=%b want 1 00100", valid_o, sel_o); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (sel_o !== 5'b0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL rmid_async sel=%b valid=%b ready=%b want 00000 0 1", sel_o, valid_o, ready_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", err_o); end
      @(negedge clk); rstn = 1'b1; ready_i = 5'b11111;
      repeat (3) @(negedge clk);
      checks++; if (valid_o !== 1'b0 || sel_o !== 5'b0) begin errors++; $display("FAIL rmid_discard valid=%b sel=%b want 0 00000", valid_o, sel_o); end
   endtask

`ifdef IU_PKT_CNT_EN
   task automatic test_pkt_cnt;
      checks++; if (pkt_cnt_o !== 16'd0) begin errors++; $display("FAIL cnt_reset got %0d want 0", pkt_cnt_o); end
      ready_i = 5'b11111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); flit_i = mk(S, 3'd2, 3'd2, 24'(i)); valid_i = 1'b1;
      end
      @(negedge clk); valid_i = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (pkt_cnt_o !== 16'd3) begin errors++; $display("FAIL cnt_three got %0d want 3", pkt_cnt_o); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single;
      test_packet;
      test_stall;
      test_dirs;
      test_back_to_back;
      test_head_in_active;
      test_err;
      test_reset_mid;
`ifdef IU_PKT_CNT_EN
      test_pkt_cnt;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
